// File: rtl/keystroke_scheduler_if.sv
// rtl/keystroke_scheduler_if.sv - key event inputs and character stream outputs of keystroke_scheduler
interface keystroke_scheduler_if #(
  parameter int DEPTH = 8
) ();
  logic                    key_valid;
  logic [7:0]              last_change;
  logic [127:0]            key_down;
  logic                    typing_en;
  logic                    flush;
  logic [7:0]              char_out;
  logic                    char_valid;
  logic                    char_ready;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output key_valid, last_change, key_down, typing_en, flush, char_ready,
    input  char_out, char_valid, overflow, count
  );

  modport slave (
    input  key_valid, last_change, key_down, typing_en, flush, char_ready,
    output char_out, char_valid, overflow, count
  );
endinterface

// File: rtl/keystroke_scheduler.sv
// rtl/keystroke_scheduler.sv - key events to buffered ASCII stream; auto-repeat under KEYSTROKE_SCHEDULER_REPEAT_EN
module keystroke_scheduler #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input logic                  clk,
  input logic                  rst,
  keystroke_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Returns {mapped, ascii}; letters come out lowercase unless shift is held.
  function automatic logic [8:0] xlate(input logic [6:0] code, input logic shift);
    logic [7:0] upper;
    logic       letter;
    logic [8:0] res;
    upper  = 8'h00;
    letter = 1'b1;
    res    = 9'h000;
    case (code)
      7'h1C: upper = 8'h41;
      7'h32: upper = 8'h42;
      7'h21: upper = 8'h43;
      7'h23: upper = 8'h44;
      7'h24: upper = 8'h45;
      7'h2B: upper = 8'h46;
      7'h34: upper = 8'h47;
      7'h33: upper = 8'h48;
      7'h43: upper = 8'h49;
      7'h3B: upper = 8'h4A;
      7'h42: upper = 8'h4B;
      7'h4B: upper = 8'h4C;
      7'h3A: upper = 8'h4D;
      7'h31: upper = 8'h4E;
      7'h44: upper = 8'h4F;
      7'h4D: upper = 8'h50;
      7'h15: upper = 8'h51;
      7'h2D: upper = 8'h52;
      7'h1B: upper = 8'h53;
      7'h2C: upper = 8'h54;
      7'h3C: upper = 8'h55;
      7'h2A: upper = 8'h56;
      7'h1D: upper = 8'h57;
      7'h22: upper = 8'h58;
      7'h35: upper = 8'h59;
      7'h1A: upper = 8'h5A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      res = {1'b1, shift ? upper : (upper | 8'h20)};
    end else begin
      case (code)
        7'h29:   res = {1'b1, 8'h20};
        7'h66:   res = {1'b1, 8'h08};
        7'h5A:   res = {1'b1, 8'h0D};
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  logic       shift;
  logic [8:0] press_map;
  logic       press_hit;
  logic       repeat_fire;
  logic [7:0] repeat_char;

  assign shift     = bus.key_down[7'h12] | bus.key_down[7'h59];
  assign press_map = xlate(bus.last_change[6:0], shift);
  assign press_hit = bus.key_valid & bus.typing_en & ~bus.flush & ~bus.last_change[7]
                   & bus.key_down[bus.last_change[6:0]] & press_map[8];

`ifdef KEYSTROKE_SCHEDULER_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  rep_state_t  state;
  logic [6:0]  held;
  logic [31:0] ctr;
  logic [8:0]  held_map;

  assign held_map    = xlate(held, shift);
  // A real press in the same cycle takes the stage, so the repeat is skipped.
  assign repeat_fire = (state != IDLE) & (ctr == '0) & bus.key_down[held] & bus.typing_en
                     & ~bus.flush & ~press_hit & held_map[8];
  assign repeat_char = held_map[7:0];

  always_ff @(posedge clk) begin
    if (rst || bus.flush || !bus.typing_en) begin
      state <= IDLE;
      held  <= '0;
      ctr   <= '0;
    end else if (press_hit) begin
      state <= DELAY;
      held  <= bus.last_change[6:0];
      ctr   <= 32'(REPEAT_DELAY - 1);
    end else if (state != IDLE) begin
      if (!bus.key_down[held]) begin
        state <= IDLE;
      end else if (ctr == '0) begin
        state <= REPEAT;
        ctr   <= 32'(REPEAT_RATE - 1);
      end else begin
        ctr <= ctr - 32'd1;
      end
    end
  end
`else
  logic [63:0] unused_cfg;
  assign unused_cfg  = {REPEAT_DELAY, REPEAT_RATE};
  assign repeat_fire = 1'b0;
  assign repeat_char = 8'h00;
`endif

  logic          stage_valid;
  logic [7:0]    stage_char;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      stage_valid <= 1'b0;
      stage_char  <= 8'h00;
    end else if (press_hit) begin
      stage_valid <= 1'b1;
      stage_char  <= press_map[7:0];
    end else if (repeat_fire) begin
      stage_valid <= 1'b1;
      stage_char  <= repeat_char;
    end else begin
      stage_valid <= 1'b0;
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          overflow_q;
  logic          full;
  logic          do_pop;
  logic          do_write;

  assign full     = (cnt == CW'(DEPTH));
  assign do_pop   = bus.char_valid & bus.char_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_write = stage_valid & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= stage_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_write) - CW'(do_pop);
      if (stage_valid && full && !do_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.char_valid = (cnt != '0);
  assign bus.char_out   = bus.char_valid ? mem[rd_ptr] : 8'h00;
  assign bus.count      = cnt;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_keystroke_scheduler.sv
// tb/tb_keystroke_scheduler.sv - scoreboard bench for keystroke_scheduler against a queue-based reference
module tb_keystroke_scheduler;
  localparam int DEPTH = 8;
  localparam int RD    = 10;
  localparam int RR    = 4;

  logic clk = 1'b0;
  logic rst;

  keystroke_scheduler_if #(.DEPTH(DEPTH)) bus ();

  keystroke_scheduler #(
    .DEPTH(DEPTH),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  letters [26];
  logic [7:0]  exp_q [$];
  int          mcount = 0;
  bit          movf   = 0;
  bit          mst_v  = 0;
  logic [7:0]  mst_c  = 8'h00;
  bit          rep_on = 0;
  logic [6:0]  held   = 7'h00;
  int          next_rep = 0;

  // Letter i of the alphabet lives at letters[i]; the three specials are fixed.
  function automatic bit ref_map(input logic [6:0] code, input bit sh, output logic [7:0] c);
    c = 8'h00;
    for (int i = 0; i < 26; i++) begin
      if ({1'b0, code} == letters[i]) begin
        c = 8'((sh ? 65 : 97) + i);
        return 1'b1;
      end
    end
    if (code == 7'h29) begin c = 8'h20; return 1'b1; end
    if (code == 7'h66) begin c = 8'h08; return 1'b1; end
    if (code == 7'h5A) begin c = 8'h0D; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit         pop;
    bit         sh;
    bit         mapped;
    logic [7:0] c;
    logic [7:0] lc;
    cyc++;
    if (rst || bus.flush) begin
      mcount = 0;
      exp_q.delete();
      mst_v  = 0;
      movf   = 0;
      rep_on = 0;
    end else begin
      pop = bus.char_ready && (mcount > 0);
      if (mst_v) begin
        if (mcount < DEPTH || pop) begin
          exp_q.push_back(mst_c);
          mcount++;
        end else begin
          movf = 1;
        end
      end
      if (pop) mcount--;
      lc     = bus.last_change;
      sh     = bus.key_down[7'h12] | bus.key_down[7'h59];
      mapped = ref_map(lc[6:0], sh, c);
      mst_v  = 0;
      if (bus.key_valid && bus.typing_en && !lc[7] && bus.key_down[lc[6:0]] && mapped) begin
        mst_v    = 1;
        mst_c    = c;
        rep_on   = 1;
        held     = lc[6:0];
        next_rep = cyc + RD;
      end
`ifdef KEYSTROKE_SCHEDULER_REPEAT_EN
      else if (rep_on) begin
        if (!bus.typing_en || !bus.key_down[held]) begin
          rep_on = 0;
        end else if (cyc == next_rep) begin
          void'(ref_map(held, sh, c));
          mst_v    = 1;
          mst_c    = c;
          next_rep = cyc + RR;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    check("count", 32'(bus.count), mcount);
    check("overflow", 32'(bus.overflow), 32'(movf));
    check("char_valid", 32'(bus.char_valid), 32'(mcount > 0));
    if (bus.char_valid && bus.char_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_underflow: got %0h expected no character at cycle %0d", bus.char_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("char_out", 32'(bus.char_out), 32'(e));
      end
    end else if (bus.char_valid && exp_q.size() > 0) begin
      check("char_head", 32'(bus.char_out), 32'(exp_q[0]));
    end else if (!bus.char_valid) begin
      check("char_out_idle", 32'(bus.char_out), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    bus.key_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic press(input logic [7:0] code);
    bus.key_down[code[6:0]] = 1'b1;
    bus.last_change         = code;
    bus.key_valid           = 1'b1;
    tick();
  endtask

  task automatic release_key(input logic [7:0] code);
    bus.key_down[code[6:0]] = 1'b0;
    bus.last_change         = code;
    bus.key_valid           = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    bus.char_ready = 1'b1;
    idle(DEPTH + 4);
    bus.char_ready = 1'b0;
  endtask

  function automatic logic [7:0] pick_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return letters[$urandom_range(0, 25)];
    if (r == 6) return 8'h29;
    if (r == 7) return ($urandom_range(0, 1) != 0) ? 8'h66 : 8'h5A;
    if (r == 8) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    rst             = 1'b1;
    bus.key_valid   = 1'b0;
    bus.last_change = 8'h00;
    bus.key_down    = '0;
    bus.typing_en   = 1'b1;
    bus.flush       = 1'b0;
    bus.char_ready  = 1'b0;
    idle(2);
    rst = 1'b0;

    press(8'h1C);
    idle(3);
    drain();

    press(8'h12);
    press(8'h2C);
    press(8'h29);
    release_key(8'h2C);
    release_key(8'h12);
    idle(3);
    drain();

    for (int i = 0; i < 9; i++) press(8'h1B);
    idle(2);
    release_key(8'h1B);
    bus.flush = 1'b1;
    tick();
    idle(2);

    for (int i = 0; i < DEPTH; i++) begin
      press(letters[i]);
      release_key(letters[i]);
    end
    idle(2);
    bus.char_ready = 1'b1;
    press(8'h4D);
    release_key(8'h4D);
    idle(DEPTH + 4);

    press(8'h23);
    idle(30);
    release_key(8'h23);
    idle(10);

    bus.char_ready = 1'b0;
    press(8'h24);
    press(8'h5A);
    press(8'h66);
    release_key(8'h24);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] code;
      bus.char_ready = ($urandom_range(0, 3) != 0);
      bus.typing_en  = ($urandom_range(0, 19) != 0);
      bus.flush      = ($urandom_range(0, 99) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) < 3) begin
        code = pick_code();
        if ($urandom_range(0, 2) != 0) begin
          bus.key_down[code[6:0]] = 1'b1;
        end else begin
          bus.key_down[code[6:0]] = 1'b0;
        end
        bus.last_change = code;
        bus.key_valid   = 1'b1;
      end
      tick();
    end
    rst = 1'b0;

    bus.typing_en  = 1'b1;
    bus.key_down   = '0;
    bus.char_ready = 1'b1;
    idle(DEPTH + 20);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
